// File: rtl/strobe_decoder4_pkg.sv
// Shared types and constants for the strobe_decoder4 block (optional accept counter: STROBE_DECODER4_CNT_EN).
package strobe_decoder4_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;

    localparam logic [ONEHOT_W-1:0] ONEHOT_0 = 4'b0001;
    localparam logic [ONEHOT_W-1:0] ONEHOT_1 = 4'b0010;
    localparam logic [ONEHOT_W-1:0] ONEHOT_2 = 4'b0100;
    localparam logic [ONEHOT_W-1:0] ONEHOT_3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/strobe_decoder4_dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module dec2to4
    import strobe_decoder4_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    input  logic                en,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            case (code)
                2'd0:    onehot = ONEHOT_0;
                2'd1:    onehot = ONEHOT_1;
                2'd2:    onehot = ONEHOT_2;
                default: onehot = ONEHOT_3;
            endcase
        end
    end

endmodule

// File: rtl/strobe_decoder4.sv
// Regenerates a one-hot strobe of HOLD_CYCLES from a 2-bit code, followed by GAP_CYCLES idle cycles.
// Optional accepted-code counter enabled by defining STROBE_DECODER4_CNT_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for a code
// DRIVE | d holds the decoded one-hot strobe
// GAP   | d is zero, enforcing spacing before the next code
module strobe_decoder4
    import strobe_decoder4_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                y0,
    input  logic                y1,
    input  logic                flush,
    output logic [ONEHOT_W-1:0] d,
    output logic                busy
`ifdef STROBE_DECODER4_CNT_EN
    ,
    output logic [15:0]         accept_cnt
`endif
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("strobe_decoder4: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 0) begin : g_bad_gap
            $error("strobe_decoder4: GAP_CYCLES must be >= 0");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ONEHOT_W-1:0]   d_nxt;
    logic [ONEHOT_W-1:0]   dec_out;
    logic                  accept;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    // flush outranks acceptance, even when sitting in IDLE
    assign accept   = in_ready & in_valid & ~flush;

    dec2to4 u_dec (
        .code   ({y1, y0}),
        .en     (accept),
        .onehot (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            d     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d     <= d_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = d;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            d_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_nxt     = dec_out;
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        d_nxt = '0;
                        if (GAP_CYCLES == 0) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = GAP_LOAD;
                            state_nxt = GAP;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    d_nxt     = '0;
                end
            endcase
        end
    end

`ifdef STROBE_DECODER4_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_cnt <= '0;
        end else if (accept) begin
            accept_cnt <= accept_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_strobe_decoder4.sv
// Directed self-checking bench for strobe_decoder4: one default instance and one HOLD=2/GAP=0 instance.
module tb_strobe_decoder4;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       va, fa, ra, ba;
    logic [1:0] ya;
    logic [3:0] da;
    logic       vb, fb, rb, bb;
    logic [1:0] yb;
    logic [3:0] db;
`ifdef STROBE_DECODER4_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    strobe_decoder4 u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (va),
        .in_ready (ra),
        .y0       (ya[0]),
        .y1       (ya[1]),
        .flush    (fa),
        .d        (da),
        .busy     (ba)
`ifdef STROBE_DECODER4_CNT_EN
        ,
        .accept_cnt (cnt_a)
`endif
    );

    strobe_decoder4 #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (vb),
        .in_ready (rb),
        .y0       (yb[0]),
        .y1       (yb[1]),
        .flush    (fb),
        .d        (db),
        .busy     (bb)
`ifdef STROBE_DECODER4_CNT_EN
        ,
        .accept_cnt (cnt_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 20 && ba; i++) tick();
        check_eq("drain_a", 16'(ba), 16'd0);
    endtask

    logic [3:0] exp_b [1:6];

    initial begin
        rst_n = 1'b0;
        va = 0; fa = 0; ya = 2'b00;
        vb = 0; fb = 0; yb = 2'b00;
        exp_b[1] = 4'b0001; exp_b[2] = 4'b0001; exp_b[3] = 4'b0000;
        exp_b[4] = 4'b1000; exp_b[5] = 4'b1000; exp_b[6] = 4'b0000;

        tick(); tick();
        check_eq("rst_d_a",    16'(da), 16'h0);
        check_eq("rst_busy_a", 16'(ba), 16'h0);
        check_eq("rst_d_b",    16'(db), 16'h0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready_a", 16'(ra), 16'h1);
        check_eq("rst_ready_b", 16'(rb), 16'h1);

        // code 10 on defaults: d=0100 on cycles 1-4, gap on 5, idle on 6
        va = 1; ya = 2'b10;
        tick();
        va = 0;
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("t1_d_c%0d", c), 16'(da), 16'h4);
            check_eq($sformatf("t1_rdy_c%0d", c), 16'(ra), 16'h0);
            tick();
        end
        check_eq("t1_gap_d",    16'(da), 16'h0);
        check_eq("t1_gap_busy", 16'(ba), 16'h1);
        check_eq("t1_gap_rdy",  16'(ra), 16'h0);
        tick();
        check_eq("t1_idle_rdy",  16'(ra), 16'h1);
        check_eq("t1_idle_busy", 16'(ba), 16'h0);
        check_eq("t1_idle_d",    16'(da), 16'h0);

        // back-to-back 00 then 11 on HOLD=2/GAP=0, in_valid held
        vb = 1; yb = 2'b00;
        tick();
        yb = 2'b11;
        for (int c = 1; c <= 6; c++) begin
            check_eq($sformatf("t2_d_c%0d", c), 16'(db), 16'(exp_b[c]));
            if (c == 3) check_eq("t2_rdy_c3", 16'(rb), 16'h1);
            if (c == 2) check_eq("t2_rdy_c2", 16'(rb), 16'h0);
            tick();
            if (c == 3) vb = 0;
        end

        // code 01, inputs wiggle during DRIVE with in_valid held high
        va = 1; ya = 2'b01;
        tick();
        for (int c = 1; c <= 4; c++) begin
            ya = ya ^ 2'(c);
            check_eq($sformatf("t3_d_c%0d", c), 16'(da), 16'h2);
            check_eq($sformatf("t3_rdy_c%0d", c), 16'(ra), 16'h0);
            tick();
        end
        check_eq("t3_gap_d", 16'(da), 16'h0);
        va = 0;
        tick();
        check_eq("t3_idle_rdy", 16'(ra), 16'h1);
        check_eq("t3_idle_d",   16'(da), 16'h0);

        // flush on DRIVE cycle 2 with a new code presented
        va = 1; ya = 2'b00;
        tick();
        va = 0;
        check_eq("t4_d_c1", 16'(da), 16'h1);
        tick();
        fa = 1; va = 1; ya = 2'b11;
        tick();
        check_eq("t4_flush_d",    16'(da), 16'h0);
        check_eq("t4_flush_busy", 16'(ba), 16'h0);
        check_eq("t4_flush_rdy",  16'(ra), 16'h1);
        fa = 0;
        tick();
        check_eq("t4_retry_d", 16'(da), 16'h8);
        va = 0;
        wait_idle_a();

        // flush in IDLE blocks acceptance
        fa = 1; va = 1; ya = 2'b01;
        tick();
        fa = 0; va = 0;
        check_eq("t4_idleflush_d",    16'(da), 16'h0);
        check_eq("t4_idleflush_busy", 16'(ba), 16'h0);
        tick();
        check_eq("t4_idleflush_d2", 16'(da), 16'h0);

`ifdef STROBE_DECODER4_CNT_EN
        check_eq("cnt_a_before_rst", cnt_a, 16'd4);
        check_eq("cnt_b_before_rst", cnt_b, 16'd2);
`endif

        // asynchronous reset in the middle of a pulse
        va = 1; ya = 2'b10;
        tick();
        va = 0;
        tick();
        check_eq("t5_pre_d", 16'(da), 16'h4);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_d",    16'(da), 16'h0);
        check_eq("t5_async_busy", 16'(ba), 16'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("t5_rel_rdy%0d", c), 16'(ra), 16'h1);
            check_eq($sformatf("t5_rel_d%0d", c),   16'(da), 16'h0);
        end

`ifdef STROBE_DECODER4_CNT_EN
        check_eq("cnt_a_after_rst", cnt_a, 16'd0);
        va = 1; ya = 2'b00;
        tick();
        va = 0;
        tick();
        fa = 1;
        tick();
        fa = 0;
        check_eq("cnt_a_after_flush", cnt_a, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
